pll_lock_monitor: RTL and testbench
===================================

# pll_lock_monitor

Supervises the lock output of the PLL calibration/init controller after calibration completes. It debounces lock, qualifies it as stable, and generates the downstream system reset. On lock loss or an init timeout it pulses the init controller's reset to rerun calibration, and enters a terminal fail state after too many retries. It sits between the init controller's `O_LOCK`/`I_RST` and the rest of the design, in the same clock domain as the init controller.

## Interface
- `CLK_PERIOD`, default 50: CLKIN period in ns.
- `STABLE_TIME`, default 100_000: ns lock must stay high before it is declared locked.
- `INIT_TIMEOUT`, default 40_000_000: ns allowed from init reset release to first lock.
- `LOSS_FILTER`, default 4: consecutive low cycles that count as lock loss (≥1).
- `INIT_RST_CYCLES`, default 4: width of the init-controller reset pulse (≥1).
- `MAX_RETRY`, default 7: number of relock attempts before fail (1..255).

Ports (one clock; reset is synchronous and active-high):
- `CLKIN` in 1: clock.
- `I_RST` in 1: synchronous, active-high reset.
- `I_LOCK` in 1: lock from the init controller. Treated as asynchronous.
- `O_INIT_RST` out 1: reset to the init controller's `I_RST`.
- `O_SYS_RST` out 1: downstream reset, active high.
- `O_LOCKED` out 1: qualified lock.
- `O_FAIL` out 1: retry budget exhausted.
- `O_RETRY_CNT` out 8: number of retries performed.

## Operation
- `I_LOCK` passes through a 2-FF synchronizer; `lock_s` is the second stage. All decisions use `lock_s`.
- Derived counts, using ceiling division:
  - `STABLE_CNT` = ceil(STABLE_TIME / CLK_PERIOD).
  - `TIMEOUT_CNT` = ceil(INIT_TIMEOUT / CLK_PERIOD).
  - A single timer is wide enough for max(STABLE_CNT, TIMEOUT_CNT, LOSS_FILTER, INIT_RST_CYCLES).
- States:
  - `INIT_RST`: `O_INIT_RST`=1. After INIT_RST_CYCLES cycles → `WAIT_LOCK`, timer cleared.
  - `WAIT_LOCK`: `lock_s`=1 → `STABLE`, timer cleared. Timer reaching TIMEOUT_CNT−1 → retry event.
  - `STABLE`: `lock_s`=0 → `WAIT_LOCK`. The timeout timer restarts from 0 and the retry count is unchanged. `lock_s` held for STABLE_CNT cycles → `LOCKED`.
  - `LOCKED`: `O_LOCKED`=1, `O_SYS_RST`=0. A loss counter counts consecutive `lock_s`=0 cycles and clears on any `lock_s`=1. Reaching LOSS_FILTER → retry event.
  - `FAIL`: terminal until `I_RST`. `O_FAIL`=1, `O_SYS_RST`=1, `O_INIT_RST`=0.
- Retry event:
  - If `O_RETRY_CNT` == MAX_RETRY → `FAIL`.
  - Otherwise `O_RETRY_CNT`++ → `INIT_RST`.
- `O_SYS_RST`=1 in every state except `LOCKED`. `O_LOCKED` drops in the same cycle as the transition out of `LOCKED`.
- A glitch shorter than LOSS_FILTER cycles in `LOCKED` causes no reaction.

## Timing
- Reset values, and the state held while `I_RST`=1:
  - state `INIT_RST`, timer 0, retry 0, synchronizer 0.
  - `O_INIT_RST`=1, `O_SYS_RST`=1, `O_LOCKED`=0, `O_FAIL`=0, `O_RETRY_CNT`=0.
- All outputs are registered. Each output changes on the clock edge where the state changes.
- After `I_RST` falls, `O_INIT_RST` stays high for exactly INIT_RST_CYCLES more cycles.
- Latency from an `I_LOCK` rise to `O_LOCKED`=1 is 2 (sync) + STABLE_CNT + 1 cycles.
- Latency from a sustained `I_LOCK` fall in `LOCKED` to `O_LOCKED`=0 and `O_INIT_RST`=1 is 2 + LOSS_FILTER cycles.
- Timeout: with no lock, the first retry occurs TIMEOUT_CNT cycles after entering `WAIT_LOCK`.
- Simultaneous events:
  - `I_RST` has priority over everything.
  - In `WAIT_LOCK`, if `lock_s` rises on the timeout cycle, lock wins → `STABLE`.
- Reset mid-operation, in any state, returns to reset values on the next edge.

## Structure
- A shared package holds:
  - the state encoding (3-bit localparams `INIT_RST`, `WAIT_LOCK`, `STABLE`, `LOCKED`, `FAIL`);
  - a ceiling-division constant function;
  - the `RETRY_W`=8 constant.
- One sub-module, `pll_lock_sync`: a 2-FF synchronizer with a synchronous clear. It is reused for other asynchronous status inputs.

## Test plan
Bench parameters: CLK_PERIOD=10, STABLE_TIME=100 (10 cycles), INIT_TIMEOUT=500 (50 cycles), LOSS_FILTER=4, INIT_RST_CYCLES=4, MAX_RETRY=2.

- Clean lock: release reset, raise `I_LOCK` at cycle 20 and hold it.
  - `O_INIT_RST` is high for 4 cycles after release.
  - `O_LOCKED` rises at cycle 33; `O_SYS_RST` falls at cycle 33.
  - `O_RETRY_CNT`=0.
- Chatter during qualify: `I_LOCK` high for 5 cycles, low for 1, then high.
  - The stable count restarts.
  - `O_LOCKED` rises 13 cycles after the final rise.
  - No retry.
- Glitch filter: in `LOCKED`, drop `I_LOCK` for 3 cycles → no change. Drop it for 4 cycles → `O_LOCKED`=0, a 4-cycle `O_INIT_RST` pulse, and `O_RETRY_CNT`=1.
- Timeout: hold `I_LOCK`=0.
  - A retry occurs every 54 cycles and `O_RETRY_CNT` goes 1, then 2.
  - The third timeout gives `O_FAIL`=1, which stays latched.
  - `O_SYS_RST`=1.
- Reset mid-operation: assert `I_RST` for 1 cycle while in `STABLE` with retry=1. All outputs return to their reset values and the count restarts from 0.
- Lock-versus-timeout tie: raise `I_LOCK` so that `lock_s` rises exactly on cycle 49 of `WAIT_LOCK` → `STABLE` is entered and the retry count is unchanged.

Source files
------------

// File: rtl/pll_lock_monitor_pkg.sv
// pll_lock_monitor_pkg: shared definitions for the PLL lock monitor.
//   state_t  - supervisor state encoding (3 bits)
//   RETRY_W  - width of the retry counter
//   ceil_div - compile-time ceiling division for ns-to-cycle conversion
//   umax     - compile-time maximum, used for timer sizing
package pll_lock_monitor_pkg;

  localparam int unsigned RETRY_W = 8;

  typedef enum logic [2:0] {
    INIT_RST  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    LOCKED    = 3'd3,
    FAIL      = 3'd4
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: 2-FF synchronizer with synchronous clear for asynchronous
// status inputs.
//   CLKIN   - destination clock
//   I_CLR   - synchronous active-high clear of both stages
//   I_ASYNC - asynchronous input
//   O_SYNC  - synchronized output (second stage)
module pll_lock_sync (
  input  logic CLKIN,
  input  logic I_CLR,
  input  logic I_ASYNC,
  output logic O_SYNC
);

  logic meta;

  always_ff @(posedge CLKIN) begin
    if (I_CLR) begin
      meta   <= 1'b0;
      O_SYNC <= 1'b0;
    end else begin
      meta   <= I_ASYNC;
      O_SYNC <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: supervises PLL lock after calibration. Debounces and
// qualifies lock, drives the downstream system reset, re-runs calibration on
// lock loss or init timeout, and latches a failure once retries run out.
//   CLKIN       - clock
//   I_RST       - synchronous active-high reset
//   I_LOCK      - lock from the init controller (asynchronous)
//   O_INIT_RST  - reset to the init controller
//   O_SYS_RST   - downstream reset, active high
//   O_LOCKED    - qualified lock
//   O_FAIL      - retry budget exhausted (terminal until I_RST)
//   O_RETRY_CNT - retries performed
module pll_lock_monitor
  import pll_lock_monitor_pkg::*;
#(
  parameter int unsigned CLK_PERIOD      = 50,
  parameter int unsigned STABLE_TIME     = 100_000,
  parameter int unsigned INIT_TIMEOUT    = 40_000_000,
  parameter int unsigned LOSS_FILTER     = 4,
  parameter int unsigned INIT_RST_CYCLES = 4,
  parameter int unsigned MAX_RETRY       = 7
) (
  input  logic               CLKIN,
  input  logic               I_RST,
  input  logic               I_LOCK,
  output logic               O_INIT_RST,
  output logic               O_SYS_RST,
  output logic               O_LOCKED,
  output logic               O_FAIL,
  output logic [RETRY_W-1:0] O_RETRY_CNT
);

  localparam int unsigned STABLE_CNT  = ceil_div(STABLE_TIME, CLK_PERIOD);
  localparam int unsigned TIMEOUT_CNT = ceil_div(INIT_TIMEOUT, CLK_PERIOD);
  localparam int unsigned TIMER_MAX   = umax(umax(STABLE_CNT, TIMEOUT_CNT),
                                             umax(LOSS_FILTER, INIT_RST_CYCLES));
  localparam int unsigned TIMER_W     = $clog2(TIMER_MAX + 1);

  // Terminal timer values: each phase ends on the cycle its count is reached.
  localparam logic [TIMER_W-1:0] INIT_LAST    = TIMER_W'(INIT_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CNT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CNT - 1);
  localparam logic [TIMER_W-1:0] LOSS_LAST    = TIMER_W'(LOSS_FILTER - 1);

  state_t               state, state_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [RETRY_W-1:0]   retry_nxt;
  logic                 retry_evt;
  logic                 lock_s;

  pll_lock_sync u_lock_sync (
    .CLKIN   (CLKIN),
    .I_CLR   (I_RST),
    .I_ASYNC (I_LOCK),
    .O_SYNC  (lock_s)
  );

  // State, timer and registered outputs; outputs follow the next state so
  // they change on the same edge as the state.
  always_ff @(posedge CLKIN) begin
    if (I_RST) begin
      state       <= INIT_RST;
      timer       <= '0;
      O_INIT_RST  <= 1'b1;
      O_SYS_RST   <= 1'b1;
      O_LOCKED    <= 1'b0;
      O_FAIL      <= 1'b0;
      O_RETRY_CNT <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      O_INIT_RST  <= (state_nxt == INIT_RST);
      O_SYS_RST   <= (state_nxt != LOCKED);
      O_LOCKED    <= (state_nxt == LOCKED);
      O_FAIL      <= (state_nxt == FAIL);
      O_RETRY_CNT <= retry_nxt;
    end
  end

  // Next-state logic. The single timer serves as init pulse counter, lock
  // timeout, stability qualifier and loss filter depending on the state.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer + TIMER_W'(1);
    retry_nxt = O_RETRY_CNT;
    retry_evt = 1'b0;

    case (state)
      INIT_RST: begin
        if (timer == INIT_LAST) begin
          state_nxt = WAIT_LOCK;
          timer_nxt = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_nxt = STABLE;
          timer_nxt = '0;
        end else if (timer == TIMEOUT_LAST) begin
          retry_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          timer_nxt = '0;
        end else if (timer == STABLE_LAST) begin
          state_nxt = LOCKED;
          timer_nxt = '0;
        end
      end
      LOCKED: begin
        // Timer counts consecutive low cycles only.
        if (lock_s) begin
          timer_nxt = '0;
        end else if (timer == LOSS_LAST) begin
          retry_evt = 1'b1;
        end
      end
      FAIL: begin
        timer_nxt = timer;
      end
      default: begin
        state_nxt = INIT_RST;
        timer_nxt = '0;
      end
    endcase

    if (retry_evt) begin
      timer_nxt = '0;
      if (O_RETRY_CNT == RETRY_W'(MAX_RETRY)) begin
        state_nxt = FAIL;
      end else begin
        retry_nxt = O_RETRY_CNT + RETRY_W'(1);
        state_nxt = INIT_RST;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: scoreboard bench for pll_lock_monitor with directed
// scenarios followed by randomized lock/reset stimulus.
module tb_pll_lock_monitor;

  localparam int P_CLK      = 10;
  localparam int P_STABLE   = 100;
  localparam int P_TIMEOUT  = 500;
  localparam int P_LOSS     = 4;
  localparam int P_INITRST  = 4;
  localparam int P_MAXRETRY = 2;

  localparam int STABLE_CNT  = (P_STABLE + P_CLK - 1) / P_CLK;
  localparam int TIMEOUT_CNT = (P_TIMEOUT + P_CLK - 1) / P_CLK;

  localparam int PH_INIT   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_QUAL   = 2;
  localparam int PH_LOCKED = 3;
  localparam int PH_FAIL   = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       lock = 1'b0;
  logic       o_init_rst, o_sys_rst, o_locked, o_fail;
  logic [7:0] o_retry;

  always #5 clk = ~clk;

  pll_lock_monitor #(
    .CLK_PERIOD      (P_CLK),
    .STABLE_TIME     (P_STABLE),
    .INIT_TIMEOUT    (P_TIMEOUT),
    .LOSS_FILTER     (P_LOSS),
    .INIT_RST_CYCLES (P_INITRST),
    .MAX_RETRY       (P_MAXRETRY)
  ) dut (
    .CLKIN       (clk),
    .I_RST       (rst),
    .I_LOCK      (lock),
    .O_INIT_RST  (o_init_rst),
    .O_SYS_RST   (o_sys_rst),
    .O_LOCKED    (o_locked),
    .O_FAIL      (o_fail),
    .O_RETRY_CNT (o_retry)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase plus time spent in it, lock seen two edges late.
  int m_s1, m_s2, m_phase, m_age, m_low, m_retries;
  logic [11:0] exp_q[$];

  task automatic m_enter(input int p);
    m_phase = p;
    m_age   = 0;
    m_low   = 0;
  endtask

  task automatic m_retry();
    if (m_retries == P_MAXRETRY) m_enter(PH_FAIL);
    else begin
      m_retries++;
      m_enter(PH_INIT);
    end
  endtask

  always @(posedge clk) begin
    int ls;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_retries = 0;
      m_enter(PH_INIT);
    end else begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(lock);
      m_age++;
      case (m_phase)
        PH_INIT:   if (m_age == P_INITRST) m_enter(PH_WAIT);
        PH_WAIT:   if (ls == 1) m_enter(PH_QUAL);
                   else if (m_age == TIMEOUT_CNT) m_retry();
        PH_QUAL:   if (ls == 0) m_enter(PH_WAIT);
                   else if (m_age == STABLE_CNT) m_enter(PH_LOCKED);
        PH_LOCKED: begin
          m_low = (ls == 1) ? 0 : m_low + 1;
          if (m_low == P_LOSS) m_retry();
        end
        default: ;
      endcase
    end
    exp_q.push_back({m_phase == PH_INIT, m_phase != PH_LOCKED, m_phase == PH_LOCKED,
                     m_phase == PH_FAIL, 8'(m_retries)});
  end

  // Monitor: compares every presented output cycle against the model.
  always @(negedge clk) begin
    logic [11:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {o_init_rst, o_sys_rst, o_locked, o_fail, o_retry};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t: got init=%b sys=%b locked=%b fail=%b retry=%0d expected init=%b sys=%b locked=%b fail=%b retry=%0d",
                 $time, a[11], a[10], a[9], a[8], a[7:0], e[11], e[10], e[9], e[8], e[7:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure_init_pulse(input string name, input int exp);
    int k = 0;
    while (o_init_rst && k < 20) begin k++; @(negedge clk); end
    check(name, k, exp);
  endtask

  task automatic measure_rise(input string name, input int exp);
    int k = 0;
    while (!o_locked && k < 40) begin @(negedge clk); k++; end
    check(name, k, exp);
  endtask

  task automatic measure_fall(input string name, input int exp);
    int k = 0;
    while (o_locked && k < 40) begin @(negedge clk); k++; end
    check(name, k, exp);
  endtask

  task automatic measure_retry(input string name, input int target, input int exp);
    int k = 0;
    while (int'(o_retry) != target && k < 200) begin @(negedge clk); k++; end
    check(name, k, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_init_rst"}, int'(o_init_rst), 1);
    check({tag, "_sys_rst"},  int'(o_sys_rst), 1);
    check({tag, "_locked"},   int'(o_locked), 0);
    check({tag, "_fail"},     int'(o_fail), 0);
    check({tag, "_retry"},    int'(o_retry), 0);
  endtask

  initial begin
    int k;
    int len;

    // Reset state and clean lock
    step(3);
    check_reset_values("reset");
    rst = 1'b0;
    measure_init_pulse("init_pulse_after_reset", P_INITRST);
    step(16);
    lock = 1'b1;
    measure_rise("clean_lock_latency", 2 + STABLE_CNT + 1);
    check("clean_sys_rst", int'(o_sys_rst), 0);
    check("clean_retry", int'(o_retry), 0);

    // Chatter during qualification restarts the stable count
    rst = 1'b1; lock = 1'b0; step(2); rst = 1'b0;
    step(14);
    lock = 1'b1; step(5);
    lock = 1'b0; step(1);
    lock = 1'b1;
    measure_rise("chatter_latency", 2 + STABLE_CNT + 1);
    check("chatter_retry", int'(o_retry), 0);

    // Glitch filter: 3 low cycles ignored, sustained low causes retry
    step(5);
    lock = 1'b0; step(P_LOSS - 1);
    lock = 1'b1; step(10);
    check("glitch3_locked", int'(o_locked), 1);
    check("glitch3_retry", int'(o_retry), 0);
    lock = 1'b0;
    measure_fall("loss_latency", 2 + P_LOSS);
    check("loss_init_rst", int'(o_init_rst), 1);
    measure_init_pulse("retry_init_pulse", P_INITRST);
    check("loss_retry", int'(o_retry), 1);

    // Reset while qualifying with retry=1
    lock = 1'b1; step(5);
    check("pre_reset_retry", int'(o_retry), 1);
    rst = 1'b1; step(1); rst = 1'b0;
    check_reset_values("midreset");
    measure_init_pulse("post_reset_pulse", P_INITRST);

    // Timeout chain into terminal failure
    rst = 1'b1; lock = 1'b0; step(2); rst = 1'b0;
    measure_retry("timeout_1", 1, P_INITRST + TIMEOUT_CNT);
    measure_retry("timeout_2", 2, P_INITRST + TIMEOUT_CNT);
    k = 0;
    while (!o_fail && k < 200) begin @(negedge clk); k++; end
    check("timeout_fail", k, P_INITRST + TIMEOUT_CNT);
    check("fail_sys_rst", int'(o_sys_rst), 1);
    check("fail_init_rst", int'(o_init_rst), 0);
    lock = 1'b1; step(30);
    check("fail_latched", int'(o_fail), 1);
    check("fail_no_lock", int'(o_locked), 0);
    check("fail_retry", int'(o_retry), 2);

    // Lock arriving on the final timeout cycle wins
    rst = 1'b1; lock = 1'b0; step(2); rst = 1'b0;
    step(P_INITRST + TIMEOUT_CNT - 3);
    lock = 1'b1;
    measure_rise("tie_latency", 2 + STABLE_CNT + 1);
    check("tie_retry", int'(o_retry), 0);

    // One cycle later the timeout wins
    rst = 1'b1; lock = 1'b0; step(2); rst = 1'b0;
    step(P_INITRST + TIMEOUT_CNT - 2);
    lock = 1'b1; step(3);
    check("late_lock_retry", int'(o_retry), 1);
    check("late_lock_init_rst", int'(o_init_rst), 1);

    // Randomized lock patterns with occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1; step(int'($urandom_range(1, 3))); rst = 1'b0;
      end
      lock = 1'($urandom_range(0, 1));
      if (lock) len = int'($urandom_range(1, 30));
      else if ($urandom_range(0, 3) == 0) len = int'($urandom_range(40, 70));
      else len = int'($urandom_range(1, 8));
      step(len);
    end

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
